// File: rtl/video_packet_send.sv
// Transmit framer: packs 16-bit pixels into 32-bit words, buffers whole lines,
// and emits FRAME / LINE / data / IDLE words on the GT TX lane.
// Ports: tx_clk, rst_n (async, active-low), vs_in, de_in, vin_data,
//        vin_width in; gt_tx_data, gt_tx_ctrl, ovf (sticky overflow) out.
// Option: VIDEO_PKT_TEST_PATTERN_EN replaces pixels by {line_idx, pix_idx}.
module video_packet_send #(
  parameter int FIFO_AW  = 11,
  parameter int VS_GUARD = 64
) (
  input  logic        tx_clk,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic [15:0] vin_data,
  input  logic [15:0] vin_width,
  output logic [31:0] gt_tx_data,
  output logic [3:0]  gt_tx_ctrl,
  output logic        ovf
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  localparam logic [31:0] K_IDLE  = 32'hff_00_00_bc;
  localparam logic [31:0] K_FRAME = 32'hff_00_01_bc;
  localparam logic [31:0] K_LINE  = 32'hff_00_02_bc;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRAME,
    S_GUARD,
    S_LINE_HDR,
    S_LINE_DATA
  } state_t;

  logic          r_vs_d;
  logic [15:0]   r_pix;
  logic [15:0]   r_lo;
  logic [15:0]   r_pend;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_ls;
  logic [PW-1:0] r_rd;
  logic          r_drop;
  logic          r_ovf;
  state_t        r_state;
  logic [15:0]   r_wcnt;
  logic [15:0]   r_gcnt;
  logic [31:0]   r_tx_data;
  logic [3:0]    r_tx_ctrl;
  logic [31:0]   r_mem [DEPTH];

  logic          w_vs_rise;
  logic [15:0]   w_w;
  logic [15:0]   w_half;
  logic [15:0]   w_pixel;
  logic [15:0]   w_pix_b;
  logic [15:0]   w_pend_b;
  logic [PW-1:0] w_wr_b;
  logic [PW-1:0] w_ls_b;
  logic [PW-1:0] w_rd_b;
  logic          w_ovf_b;
  logic          w_drop_b;
  logic          w_full;
  logic [15:0]   w_pix_n;
  logic [PW-1:0] w_wr_n;
  logic [PW-1:0] w_ls_n;
  logic          w_ovf_n;
  logic          w_drop_n;
  logic [15:0]   w_lo_n;
  logic          w_inc;
  logic          w_dec;
  logic          w_we;
  logic [31:0]   w_wdata;

  assign w_vs_rise = vs_in & ~r_vs_d;
  assign w_w       = vin_width & 16'hfffe;
  assign w_half    = w_w >> 1;

  // A frame edge flushes everything; the pixel path then works from
  // these flushed values so a pixel in the edge cycle becomes pixel 0.
  assign w_pix_b  = w_vs_rise ? '0 : r_pix;
  assign w_pend_b = w_vs_rise ? '0 : r_pend;
  assign w_wr_b   = w_vs_rise ? '0 : r_wr;
  assign w_ls_b   = w_vs_rise ? '0 : r_ls;
  assign w_rd_b   = w_vs_rise ? '0 : r_rd;
  assign w_ovf_b  = w_vs_rise ? 1'b0 : r_ovf;
  assign w_drop_b = w_vs_rise ? 1'b0 : r_drop;
  assign w_full   = (w_wr_b - w_rd_b) == PW'(DEPTH);

`ifdef VIDEO_PKT_TEST_PATTERN_EN
  logic [15:0] r_line;
  logic [15:0] w_line_b;
  assign w_line_b = w_vs_rise ? '0 : r_line;
  assign w_pixel  = {w_line_b[7:0], w_pix_b[7:0]};
`else
  assign w_pixel  = vin_data;
`endif

  assign w_wdata = {w_pixel, r_lo};
  assign w_dec   = (r_state == S_IDLE) && (r_pend != '0) && !w_vs_rise;

  always_comb begin
    w_pix_n  = w_pix_b;
    w_wr_n   = w_wr_b;
    w_ls_n   = w_ls_b;
    w_ovf_n  = w_ovf_b;
    w_drop_n = w_drop_b;
    w_lo_n   = r_lo;
    w_inc    = 1'b0;
    w_we     = 1'b0;
    if (!de_in) begin
      w_drop_n = 1'b0;
      // burst ended short of a full line: forget it
      if (w_pix_b != '0) begin
        w_wr_n  = w_ls_b;
        w_pix_n = '0;
      end
    end else if (!w_drop_b && (w_w != '0)) begin
      if (!w_pix_b[0]) begin
        w_lo_n  = w_pixel;
        w_pix_n = w_pix_b + 16'd1;
      end else if (w_full) begin
        w_ovf_n  = 1'b1;
        w_drop_n = 1'b1;
        w_wr_n   = w_ls_b;
        w_pix_n  = '0;
      end else begin
        w_we   = 1'b1;
        w_wr_n = w_wr_b + PW'(1);
        if (w_pix_b + 16'd1 == w_w) begin
          // line complete; extra pixels of this burst are ignored
          w_pix_n  = '0;
          w_ls_n   = w_wr_b + PW'(1);
          w_inc    = 1'b1;
          w_drop_n = 1'b1;
        end else begin
          w_pix_n = w_pix_b + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (w_we) r_mem[w_wr_b[FIFO_AW-1:0]] <= w_wdata;
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_pix  <= '0;
      r_lo   <= '0;
      r_pend <= '0;
      r_wr   <= '0;
      r_ls   <= '0;
      r_drop <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_vs_d <= vs_in;
      r_pix  <= w_pix_n;
      r_lo   <= w_lo_n;
      r_pend <= w_pend_b + {15'd0, w_inc} - {15'd0, w_dec};
      r_wr   <= w_wr_n;
      r_ls   <= w_ls_n;
      r_drop <= w_drop_n;
      r_ovf  <= w_ovf_n;
    end
  end

`ifdef VIDEO_PKT_TEST_PATTERN_EN
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) r_line <= '0;
    else        r_line <= w_line_b + {15'd0, w_inc};
  end
`endif

  // Output register always holds the word of the state being entered.
  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx_data <= K_IDLE;
      r_tx_ctrl <= 4'b0001;
      r_rd      <= '0;
      r_wcnt    <= '0;
      r_gcnt    <= '0;
    end else if (w_vs_rise) begin
      r_state   <= S_FRAME;
      r_tx_data <= K_FRAME;
      r_tx_ctrl <= 4'b0001;
      r_rd      <= '0;
    end else begin
      r_tx_data <= K_IDLE;
      r_tx_ctrl <= 4'b0001;
      unique case (r_state)
        S_IDLE: begin
          if (r_pend != '0) begin
            r_state   <= S_LINE_HDR;
            r_tx_data <= K_LINE;
          end
        end
        S_FRAME: begin
          r_state <= S_GUARD;
          r_gcnt  <= '0;
        end
        S_GUARD: begin
          if (r_gcnt == 16'(VS_GUARD - 1)) r_state <= S_IDLE;
          else r_gcnt <= r_gcnt + 16'd1;
        end
        S_LINE_HDR: begin
          if (w_half == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_LINE_DATA;
            r_tx_data <= r_mem[r_rd[FIFO_AW-1:0]];
            r_tx_ctrl <= 4'b0000;
            r_rd      <= r_rd + PW'(1);
            r_wcnt    <= 16'd1;
          end
        end
        S_LINE_DATA: begin
          if (r_wcnt >= w_half) begin
            r_state <= S_IDLE;
          end else begin
            r_tx_data <= r_mem[r_rd[FIFO_AW-1:0]];
            r_tx_ctrl <= 4'b0000;
            r_rd      <= r_rd + PW'(1);
            r_wcnt    <= r_wcnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gt_tx_data = r_tx_data;
  assign gt_tx_ctrl = r_tx_ctrl;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_video_packet_send.sv
// Bench for video_packet_send: random video in, lane stream parsed and
// compared against a line-level model of what should be framed.
module tb_video_packet_send;

  localparam int DEPTH = 2048;
  localparam logic [31:0] IDLE_W  = 32'hff0000bc;
  localparam logic [31:0] FRAME_W = 32'hff0001bc;
  localparam logic [31:0] LINE_W  = 32'hff0002bc;

  logic        tx_clk = 1'b0;
  logic        rst_n;
  logic        vs_in;
  logic        de_in;
  logic [15:0] vin_data;
  logic [15:0] vin_width;
  logic [31:0] gt_tx_data;
  logic [3:0]  gt_tx_ctrl;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 tx_clk = ~tx_clk;

  video_packet_send dut (
    .tx_clk    (tx_clk),
    .rst_n     (rst_n),
    .vs_in     (vs_in),
    .de_in     (de_in),
    .vin_data  (vin_data),
    .vin_width (vin_width),
    .gt_tx_data(gt_tx_data),
    .gt_tx_ctrl(gt_tx_ctrl),
    .ovf       (ovf)
  );

  logic [31:0] rx_d[$];
  logic [3:0]  rx_c[$];
  bit          mon_en = 1'b0;

  always @(negedge tx_clk) begin
    if (mon_en) begin
      rx_d.push_back(gt_tx_data);
      rx_c.push_back(gt_tx_ctrl);
    end
  end

  int          m_w;
  int          m_line_idx;
  logic [31:0] exp_words[$];
  int          exp_lines;
  bit          exp_ovf;

  int          p_frames, p_hdrs, p_lines, p_trunc, p_stray, p_min_guard;
  logic [31:0] p_words[$];

  task automatic clear_rx();
    rx_d.delete();
    rx_c.delete();
    exp_words.delete();
    exp_lines = 0;
    exp_ovf   = 1'b0;
  endtask

  task automatic set_width(input int w);
    vin_width = 16'(w);
    m_w = (w / 2) * 2;
  endtask

  task automatic vs_pulse();
    @(negedge tx_clk);
    vs_in = 1'b1;
    m_line_idx = 0;
    @(negedge tx_clk);
    vs_in = 1'b0;
  endtask

  // One de burst. A burst of at least W pixels yields exactly one line
  // made of its first W pixels; anything shorter yields nothing.
  task automatic drive_burst(input int n, input int blank,
                             input bit with_vs, input bit seq);
    logic [15:0] px[$];
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      @(negedge tx_clk);
      vs_in = with_vs && (i == 0);
      if (with_vs && i == 0) m_line_idx = 0;
      vin_data = seq ? 16'(i + 1) : 16'($urandom);
`ifdef VIDEO_PKT_TEST_PATTERN_EN
      p = {8'(m_line_idx), 8'(i)};
`else
      p = vin_data;
`endif
      px.push_back(p);
      de_in = 1'b1;
    end
    @(negedge tx_clk);
    de_in = 1'b0;
    vs_in = 1'b0;
    repeat (blank) @(negedge tx_clk);
    if (m_w > 0 && n >= m_w) begin
      // only used with an otherwise empty buffer
      if (m_w / 2 > DEPTH) begin
        exp_ovf = 1'b1;
      end else begin
        for (int k = 0; k < m_w; k += 2)
          exp_words.push_back({px[k+1], px[k]});
        exp_lines++;
        m_line_idx++;
      end
    end
  endtask

  task automatic parse(input int w);
    int rem;
    int idle_run;
    bit after_frame;
    logic [31:0] cur[$];
    p_frames = 0; p_hdrs = 0; p_lines = 0;
    p_trunc = 0; p_stray = 0; p_min_guard = 1 << 30;
    p_words.delete();
    rem = 0; idle_run = 0; after_frame = 1'b0;
    foreach (rx_d[i]) begin
      if (rx_c[i] == 4'b0000) begin
        if (rem > 0) begin
          cur.push_back(rx_d[i]);
          rem--;
          if (rem == 0) begin
            p_lines++;
            foreach (cur[j]) p_words.push_back(cur[j]);
            cur.delete();
          end
        end else begin
          p_stray++;
        end
      end else begin
        if (rem > 0) begin
          p_trunc++;
          rem = 0;
          cur.delete();
        end
        if (rx_c[i] == 4'b0001 && rx_d[i] == IDLE_W) begin
          if (after_frame) idle_run++;
        end else begin
          if (after_frame && idle_run < p_min_guard) p_min_guard = idle_run;
          after_frame = 1'b0;
          if (rx_c[i] == 4'b0001 && rx_d[i] == FRAME_W) begin
            p_frames++;
            after_frame = 1'b1;
            idle_run = 0;
          end else if (rx_c[i] == 4'b0001 && rx_d[i] == LINE_W) begin
            p_hdrs++;
            rem = w / 2;
          end else begin
            p_stray++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs_in = 1'b0; de_in = 1'b0;
    vin_data = '0; set_width(8);
    repeat (3) @(negedge tx_clk);
    checks++;
    if ({gt_tx_data, gt_tx_ctrl, ovf} !== {IDLE_W, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL rst_in got %h/%b/%b want %h/0001/0",
               gt_tx_data, gt_tx_ctrl, ovf, IDLE_W);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge tx_clk);
      checks++;
      if ({gt_tx_data, gt_tx_ctrl, ovf} !== {IDLE_W, 4'b0001, 1'b0}) begin
        errors++;
        $display("FAIL rst_idle got %h/%b/%b want %h/0001/0",
                 gt_tx_data, gt_tx_ctrl, ovf, IDLE_W);
      end
    end
  endtask

  task automatic test_frame_line();
    logic [31:0] lit[4];
    lit = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
    clear_rx();
    set_width(8);
    drive_burst(8, 100, 1'b1, 1'b1);
    parse(8);
    checks++;
    if (p_frames !== 1) begin errors++;
      $display("FAIL fl_frames got %0d want 1", p_frames); end
    checks++;
    if (!(p_min_guard >= 64)) begin errors++;
      $display("FAIL fl_guard got %0d want >=64", p_min_guard); end
    checks++;
    if (p_hdrs !== 1 || p_lines !== 1) begin errors++;
      $display("FAIL fl_lines got %0d/%0d want 1/1", p_hdrs, p_lines); end
    checks++;
    if (p_trunc !== 0 || p_stray !== 0) begin errors++;
      $display("FAIL fl_junk got %0d/%0d want 0/0", p_trunc, p_stray); end
`ifndef VIDEO_PKT_TEST_PATTERN_EN
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= p_words.size() || p_words[k] !== lit[k]) begin errors++;
        $display("FAIL fl_word%0d got %h want %h", k,
                 (k < p_words.size()) ? p_words[k] : 32'hx, lit[k]); end
    end
`endif
    checks++;
    if (rx_d[$] !== IDLE_W || rx_c[$] !== 4'b0001) begin errors++;
      $display("FAIL fl_tail got %h/%b want %h/0001", rx_d[$], rx_c[$], IDLE_W); end
  endtask

  task automatic test_random_frames();
    int kind, n, bad;
    for (int f = 0; f < 3; f++) begin
      clear_rx();
      set_width($urandom_range(2, 65));
      vs_pulse();
      for (int b = 0; b < 25; b++) begin
        kind = $urandom_range(0, 2);
        if (kind == 0 || m_w < 2) n = m_w;
        else if (kind == 1) n = $urandom_range(1, m_w - 1);
        else n = m_w + $urandom_range(1, 8);
        drive_burst(n, $urandom_range(1, 30), 1'b0, 1'b0);
      end
      repeat (300) @(negedge tx_clk);
      parse(m_w);
      checks++;
      if (p_frames !== 1 || !(p_min_guard >= 64)) begin errors++;
        $display("FAIL rnd_frame f%0d got %0d/%0d want 1/>=64",
                 f, p_frames, p_min_guard); end
      checks++;
      if (p_hdrs !== exp_lines || p_lines !== exp_lines) begin errors++;
        $display("FAIL rnd_lines f%0d got %0d/%0d want %0d",
                 f, p_hdrs, p_lines, exp_lines); end
      bad = (p_words.size() != exp_words.size()) ? 1 : 0;
      foreach (exp_words[k])
        if (k < p_words.size() && p_words[k] !== exp_words[k]) bad++;
      checks++;
      if (bad != 0) begin errors++;
        $display("FAIL rnd_words f%0d got %0d bad words want 0", f, bad); end
      checks++;
      if (p_trunc !== 0 || p_stray !== 0 || ovf !== 1'b0) begin errors++;
        $display("FAIL rnd_junk f%0d got %0d/%0d/%b want 0/0/0",
                 f, p_trunc, p_stray, ovf); end
    end
  endtask

  task automatic test_zero_width();
    for (int w = 0; w < 2; w++) begin
      clear_rx();
      set_width(w);
      vs_pulse();
      drive_burst(6, 2, 1'b0, 1'b0);
      drive_burst(1, 2, 1'b0, 1'b0);
      drive_burst(12, 80, 1'b0, 1'b0);
      parse(m_w);
      checks++;
      if (p_hdrs !== 0 || p_stray !== 0) begin errors++;
        $display("FAIL zero_w%0d got %0d/%0d want 0/0", w, p_hdrs, p_stray); end
    end
  endtask

  task automatic test_big_width();
    int bad;
    clear_rx();
    set_width(1920);
    vs_pulse();
    for (int l = 0; l < 3; l++) drive_burst(1920, 200, 1'b0, 1'b0);
    repeat (1200) @(negedge tx_clk);
    parse(1920);
    checks++;
    if (p_hdrs !== 3 || p_lines !== 3) begin errors++;
      $display("FAIL big_lines got %0d/%0d want 3/3", p_hdrs, p_lines); end
    bad = (p_words.size() != exp_words.size()) ? 1 : 0;
    foreach (exp_words[k])
      if (k < p_words.size() && p_words[k] !== exp_words[k]) bad++;
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL big_words got %0d bad words want 0", bad); end
    checks++;
    if (ovf !== 1'b0 || p_trunc !== 0) begin errors++;
      $display("FAIL big_ovf got %b/%0d want 0/0", ovf, p_trunc); end
  endtask

  task automatic test_partial();
    int bad;
    clear_rx();
    set_width(16);
    vs_pulse();
    repeat (70) @(negedge tx_clk);
    drive_burst(10, 5, 1'b0, 1'b0);
    drive_burst(16, 40, 1'b0, 1'b0);
    parse(16);
    checks++;
    if (p_hdrs !== 1 || p_lines !== 1) begin errors++;
      $display("FAIL part_lines got %0d/%0d want 1/1", p_hdrs, p_lines); end
    bad = (p_words.size() != exp_words.size()) ? 1 : 0;
    foreach (exp_words[k])
      if (k < p_words.size() && p_words[k] !== exp_words[k]) bad++;
    checks++;
    if (bad != 0) begin errors++;
      $display("FAIL part_words got %0d bad words want 0", bad); end
  endtask

  task automatic test_overflow();
    int bad;
    clear_rx();
    set_width(5000);
    vs_pulse();
    drive_burst(5000, 5, 1'b0, 1'b0);
    checks++;
    if (ovf !== exp_ovf) begin errors++;
      $display("FAIL ovf_set got %b want %b", ovf, exp_ovf); end
    parse(m_w);
    checks++;
    if (p_hdrs !== 0) begin errors++;
      $display("FAIL ovf_nolines got %0d want 0", p_hdrs); end
    set_width(8);
    vs_pulse();
    checks++;
    if (ovf !== 1'b0) begin errors++;
      $display("FAIL ovf_clear got %b want 0", ovf); end
    clear_rx();
    repeat (80) @(negedge tx_clk);
    drive_burst(8, 30, 1'b0, 1'b0);
    parse(8);
    bad = (p_words.size() != exp_words.size()) ? 1 : 0;
    foreach (exp_words[k])
      if (k < p_words.size() && p_words[k] !== exp_words[k]) bad++;
    checks++;
    if (p_lines !== 1 || bad != 0) begin errors++;
      $display("FAIL ovf_recover got %0d lines %0d bad want 1/0", p_lines, bad); end
  endtask

  task automatic test_vs_abort();
    int cnt, fi, nd, after_d, after_l;
    bit hit;
    clear_rx();
    set_width(1920);
    vs_pulse();
    drive_burst(1920, 0, 1'b0, 1'b0);
    cnt = 0; hit = 1'b0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge tx_clk);
      if (gt_tx_ctrl == 4'b0000) cnt++;
      if (cnt == 3) begin vs_in = 1'b1; hit = 1'b1; end
    end
    checks++;
    if (!hit) begin errors++;
      $display("FAIL abort_wait got %0d data words want 3", cnt); end
    @(negedge tx_clk);
    vs_in = 1'b0;
    repeat (100) @(negedge tx_clk);
    fi = -1; nd = 0; after_d = 0; after_l = 0;
    foreach (rx_d[i]) begin
      if (rx_c[i] == 4'b0001 && rx_d[i] == FRAME_W) fi = i;
      if (rx_c[i] == 4'b0000) nd++;
    end
    foreach (rx_d[i]) begin
      if (i > fi && rx_c[i] == 4'b0000) after_d++;
      if (i > fi && rx_c[i] == 4'b0001 && rx_d[i] == LINE_W) after_l++;
    end
    checks++;
    if (fi < 1 || rx_c[fi-1] !== 4'b0000 || rx_d[fi-1] !== exp_words[2]) begin
      errors++;
      $display("FAIL abort_edge got %h want %h before FRAME",
               (fi >= 1) ? rx_d[fi-1] : 32'hx, exp_words[2]);
    end
    checks++;
    if (nd !== 3 || after_d !== 0 || after_l !== 0) begin errors++;
      $display("FAIL abort_rest got %0d/%0d/%0d want 3/0/0", nd, after_d, after_l); end
  endtask

  task automatic test_reset_midline();
    int bad;
    set_width(8);
    drive_burst(8, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge tx_clk);
      de_in = 1'b1;
      vin_data = 16'($urandom);
    end
    @(negedge tx_clk);
    rst_n = 1'b0;
    de_in = 1'b0;
    #1;
    checks++;
    if ({gt_tx_data, gt_tx_ctrl, ovf} !== {IDLE_W, 4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL mrst_out got %h/%b/%b want %h/0001/0",
               gt_tx_data, gt_tx_ctrl, ovf, IDLE_W);
    end
    @(negedge tx_clk);
    rst_n = 1'b1;
    clear_rx();
    drive_burst(8, 40, 1'b0, 1'b0);
    parse(8);
    bad = (p_words.size() != exp_words.size()) ? 1 : 0;
    foreach (exp_words[k])
      if (k < p_words.size() && p_words[k] !== exp_words[k]) bad++;
    checks++;
    if (p_hdrs !== 1 || p_lines !== 1 || bad != 0 || p_stray !== 0) begin
      errors++;
      $display("FAIL mrst_line got %0d/%0d bad %0d stray %0d want 1/1/0/0",
               p_hdrs, p_lines, bad, p_stray);
    end
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_frame_line();
    test_random_frames();
    test_zero_width();
    test_big_width();
    test_partial();
    test_overflow();
    test_vs_abort();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
